ucie_ctl_rx_fsm_mc: RTL and testbench
=====================================

# ucie_ctl_rx_fsm_mc

Parametrised multi-channel receive-side control FSM for the UCIe controller. It is the next generation of the single-channel RX FSM. Each of `N_CH` channels independently gates its RX buffer from a state request and tracks overflow events. New behaviour over the single-channel block:
- a configurable sticky/auto-recover overflow mode;
- a timed RECOVER state before re-arming;
- saturating per-channel overflow counters;
- fully defined outputs in every state (no latches).

It sits between the link-state logic and the per-channel RX buffers.

## Interface
Parameters:
- `N_CH`, 4: number of independent channels (≥1).
- `STICKY_OVF`, 0: 0 = OVERFLOW lasts one cycle then auto-recovers; 1 = OVERFLOW held until `i_ovf_clear[ch]`.
- `RECOVER_CYCLES`, 8: cycles spent in RECOVER (≥1).
- `CNT_W`, 8: width of each per-channel overflow counter.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_state_request`  in  N_CH  per-channel request to enter/remain ACTIVE.
- `i_overflow_detected`  in  N_CH  per-channel overflow indication from the buffer.
- `i_ovf_clear`  in  N_CH  exits OVERFLOW when `STICKY_OVF=1`; ignored otherwise.
- `i_cnt_clear`  in  N_CH  clears that channel's overflow counter.
- `o_buffer_enable`  out  N_CH  1 only while the channel is in ACTIVE.
- `o_overflow_detected`  out  N_CH  1 only while the channel is in OVERFLOW.
- `o_recovering`  out  N_CH  1 only while the channel is in RECOVER.
- `o_overflow_any`  out  1  OR-reduction of `o_overflow_detected`.
- `o_overflow_count`  out  N_CH*CNT_W  packed counters; channel k occupies `[k*CNT_W +: CNT_W]`.

## Operation
Per-channel states are one-hot: IDLE, ACTIVE, OVERFLOW, RECOVER.

Transitions, listed in priority order within each state:
- **IDLE:** `req` -> ACTIVE; otherwise stay.
- **ACTIVE:** `!req` -> IDLE, and this has priority over overflow; else `ovf` -> OVERFLOW; else stay.
- **OVERFLOW:**
  - `STICKY_OVF=0`: -> RECOVER unconditionally.
  - `STICKY_OVF=1`: `i_ovf_clear` -> RECOVER; else stay.
  - `req` and `ovf` are ignored in this state.
- **RECOVER:**
  - On entry the down-counter loads `RECOVER_CYCLES-1` and decrements each cycle.
  - At 0 -> IDLE.
  - `req` and `ovf` are ignored.
  - From IDLE, `req` must then be re-asserted (or still be high) to return to ACTIVE.
- Illegal or non-one-hot encoding -> IDLE on the next cycle, with all outputs 0.

Outputs:
- All outputs are Moore, decoded from the registered state.
- Every output is assigned in every state; no latches are inferred.

Overflow counter:
- Increments on each ACTIVE->OVERFLOW transition.
- Saturates at 2^CNT_W-1 and never wraps.
- If `i_cnt_clear` and an increment occur in the same cycle, the counter becomes 1.
- `i_cnt_clear` alone sets the counter to 0.

Channels share nothing except `i_clk` and `i_rst`. An event on one channel never affects another.

## Timing
- **Reset:** `i_rst` high at an edge puts every channel in IDLE, clears RECOVER counters, and clears all overflow counters to 0.
  - After that edge all outputs read 0.
  - Reset asserted mid-ACTIVE, mid-OVERFLOW or mid-RECOVER aborts immediately, with the same result.
- **Request latency:** `req` high in IDLE at edge t -> `o_buffer_enable` = 1 after edge t (1 cycle).
- **Overflow latency:** `ovf` high in ACTIVE at edge t -> after edge t, `o_buffer_enable`=0, `o_overflow_detected`=1 and the count has incremented.
- **Auto-recover mode (`STICKY_OVF=0`):**
  - `o_overflow_detected` is high for exactly 1 cycle.
  - `o_recovering` is then high for exactly `RECOVER_CYCLES` cycles.
  - IDLE follows.
  - Earliest return to ACTIVE is `RECOVER_CYCLES+2` cycles after the overflow edge.
- **Sticky mode (`STICKY_OVF=1`):** `i_ovf_clear` at edge t -> RECOVER after edge t.
- **Simultaneous `!req` and `ovf` in ACTIVE:** go to IDLE; no count increment.

## Structure
- **Package `ucie_ctl_rx_pkg`:**
  - State encoding constants: IDLE=4'b0001, ACTIVE=4'b0010, OVERFLOW=4'b0100, RECOVER=4'b1000.
  - Default values for `RECOVER_CYCLES` and `CNT_W`.
- **Sub-module `ucie_ctl_rx_ch_fsm`:**
  - One channel: state register, RECOVER counter and saturating counter.
  - Instantiated `N_CH` times via generate.
  - The top level only slices the buses and OR-reduces `o_overflow_any`.

## Test plan
- **Reset/basic:** `N_CH=4`, reset for 2 cycles, then `req[2]`=1 -> only `o_buffer_enable[2]` rises, 1 cycle later; all other outputs stay 0.
- **Auto-recover:** `STICKY_OVF=0`, `RECOVER_CYCLES=3`, `ovf[0]` pulse in ACTIVE -> expect overflow for 1 cycle, `recovering` for 3 cycles, then IDLE, then ACTIVE again on the next cycle since `req` is held; `count[0]`=1.
- **Sticky:** `STICKY_OVF=1`, overflow then no clear for 20 cycles -> `o_overflow_detected` held high for all 20; `i_ovf_clear` -> RECOVER on the next cycle.
- **Priority:** `req` drops in the same cycle `ovf` rises -> IDLE, `count` unchanged, `o_overflow_detected` never 1.
- **Saturation/clear:** `CNT_W=2`, 5 overflow cycles -> count stays at 3. Then `i_cnt_clear` together with a new overflow -> count=1.
- **Reset mid-op:** `i_rst` asserted during RECOVER on channel 1 and OVERFLOW on channel 3 -> all outputs and counts are 0 after the edge.

Source files
------------

// File: rtl/ucie_ctl_rx_fsm_mc_pkg.sv
// Shared definitions for the multi-channel UCIe RX control FSM:
// one-hot channel state encoding and default sizing constants.
package ucie_ctl_rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ACTIVE = 4'b0010,
        ST_OVF    = 4'b0100,
        ST_REC    = 4'b1000
    } rx_state_e;

    localparam int RECOVER_CYCLES_DEF = 8;
    localparam int CNT_W_DEF          = 8;

endpackage

// File: rtl/ucie_ctl_rx_fsm_mc_if.sv
// Control bus between link-state logic and the RX FSM block.
// master: drives requests/clears; slave: drives per-channel status.
interface ucie_ctl_rx_fsm_mc_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       i_state_request;
    logic [N_CH-1:0]       i_overflow_detected;
    logic [N_CH-1:0]       i_ovf_clear;
    logic [N_CH-1:0]       i_cnt_clear;
    logic [N_CH-1:0]       o_buffer_enable;
    logic [N_CH-1:0]       o_overflow_detected;
    logic [N_CH-1:0]       o_recovering;
    logic                  o_overflow_any;
    logic [N_CH*CNT_W-1:0] o_overflow_count;

    modport master (
        output i_state_request, i_overflow_detected,
        output i_ovf_clear, i_cnt_clear,
        input  o_buffer_enable, o_overflow_detected,
        input  o_recovering, o_overflow_any, o_overflow_count
    );

    modport slave (
        input  i_state_request, i_overflow_detected,
        input  i_ovf_clear, i_cnt_clear,
        output o_buffer_enable, o_overflow_detected,
        output o_recovering, o_overflow_any, o_overflow_count
    );
endinterface

// File: rtl/ucie_ctl_rx_fsm_mc_ch_fsm.sv
// Single-channel RX FSM: state register, RECOVER down-counter and
// saturating overflow counter. Ports: clk/rst, req/ovf/clear inputs,
// Moore status outputs and the channel's overflow count.
module ucie_ctl_rx_ch_fsm
    import ucie_ctl_rx_pkg::*;
#(
    parameter int STICKY_OVF     = 0,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_ovf,
    input  logic             i_ovf_clear,
    input  logic             i_cnt_clear,
    output logic             o_buffer_enable,
    output logic             o_overflow_detected,
    output logic             o_recovering,
    output logic [CNT_W-1:0] o_overflow_count
);
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [RW-1:0]    rcnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             inc;

    always_comb begin
        state_d             = ST_IDLE;
        inc                 = 1'b0;
        o_buffer_enable     = 1'b0;
        o_overflow_detected = 1'b0;
        o_recovering        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = i_req ? ST_ACTIVE : ST_IDLE;
            end
            ST_ACTIVE: begin
                o_buffer_enable = 1'b1;
                // Dropping the request wins over a same-cycle overflow.
                if (!i_req) begin
                    state_d = ST_IDLE;
                end else if (i_ovf) begin
                    state_d = ST_OVF;
                    inc     = 1'b1;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_OVF: begin
                o_overflow_detected = 1'b1;
                if ((STICKY_OVF == 0) || i_ovf_clear) begin
                    state_d = ST_REC;
                end else begin
                    state_d = ST_OVF;
                end
            end
            ST_REC: begin
                o_recovering = 1'b1;
                state_d      = (rcnt_q == '0) ? ST_IDLE : ST_REC;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RECOVER is only entered from OVERFLOW, so preloading there
    // gives RECOVER_CYCLES cycles of recovery.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rcnt_q <= '0;
        end else if (state_q == ST_OVF) begin
            rcnt_q <= RW'(RECOVER_CYCLES - 1);
        end else if ((state_q == ST_REC) && (rcnt_q != '0)) begin
            rcnt_q <= rcnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_cnt_clear) begin
            cnt_q <= inc ? CNT_W'(1) : '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_overflow_count = cnt_q;

endmodule

// File: rtl/ucie_ctl_rx_fsm_mc.sv
// Multi-channel UCIe RX control FSM top: N_CH independent channel FSMs.
// Ports: i_clk, i_rst, and the control bus (slave side) with status.
module ucie_ctl_rx_fsm_mc
    import ucie_ctl_rx_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int STICKY_OVF     = 0,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ucie_ctl_rx_fsm_mc_if.slave   bus
);
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       ovf;
    logic [N_CH-1:0]       rec;
    logic [N_CH*CNT_W-1:0] cnt;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ucie_ctl_rx_ch_fsm #(
            .STICKY_OVF     (STICKY_OVF),
            .RECOVER_CYCLES (RECOVER_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .i_clk               (i_clk),
            .i_rst               (i_rst),
            .i_req               (bus.i_state_request[k]),
            .i_ovf               (bus.i_overflow_detected[k]),
            .i_ovf_clear         (bus.i_ovf_clear[k]),
            .i_cnt_clear         (bus.i_cnt_clear[k]),
            .o_buffer_enable     (en[k]),
            .o_overflow_detected (ovf[k]),
            .o_recovering        (rec[k]),
            .o_overflow_count    (cnt[k*CNT_W +: CNT_W])
        );
    end

    assign bus.o_buffer_enable     = en;
    assign bus.o_overflow_detected = ovf;
    assign bus.o_recovering        = rec;
    assign bus.o_overflow_count    = cnt;
    assign bus.o_overflow_any      = |ovf;

endmodule

// File: tb/tb_ucie_ctl_rx_fsm_mc.sv
// Bench for ucie_ctl_rx_fsm_mc: auto-recover and sticky instances share
// stimulus; directed tables, corner sequences and random vs. a model.
module tb_ucie_ctl_rx_fsm_mc;

    localparam int RC = 3;
    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_OVF  = 2;
    localparam int M_REC  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] ovf = '0;
    logic [3:0] oclr = '0;
    logic [3:0] cclr = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucie_ctl_rx_fsm_mc_if #(.N_CH(4), .CNT_W(2)) ifa ();
    ucie_ctl_rx_fsm_mc_if #(.N_CH(4), .CNT_W(4)) ifb ();

    assign ifa.i_state_request     = req;
    assign ifa.i_overflow_detected = ovf;
    assign ifa.i_ovf_clear         = oclr;
    assign ifa.i_cnt_clear         = cclr;
    assign ifb.i_state_request     = req;
    assign ifb.i_overflow_detected = ovf;
    assign ifb.i_ovf_clear         = oclr;
    assign ifb.i_cnt_clear         = cclr;

    ucie_ctl_rx_fsm_mc #(
        .N_CH(4), .STICKY_OVF(0), .RECOVER_CYCLES(RC), .CNT_W(2)
    ) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa.slave)
    );

    ucie_ctl_rx_fsm_mc #(
        .N_CH(4), .STICKY_OVF(1), .RECOVER_CYCLES(RC), .CNT_W(4)
    ) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb.slave)
    );

    // Reference model: per-channel mode, remaining recovery cycles
    // and overflow tally (dut 0 = auto-recover, dut 1 = sticky).
    int md   [2][4];
    int left [2][4];
    int cnt  [2][4];
    int sticky [2] = '{0, 1};
    int cmax   [2] = '{3, 15};
    int cw     [2] = '{2, 4};

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                bit inc = 1'b0;
                if (rst) begin
                    md[d][c] = M_IDLE;
                    left[d][c] = 0;
                    cnt[d][c] = 0;
                    continue;
                end
                if (md[d][c] == M_IDLE) begin
                    if (req[c]) md[d][c] = M_ACT;
                end else if (md[d][c] == M_ACT) begin
                    if (!req[c]) md[d][c] = M_IDLE;
                    else if (ovf[c]) begin
                        md[d][c] = M_OVF;
                        inc = 1'b1;
                    end
                end else if (md[d][c] == M_OVF) begin
                    if (sticky[d] == 0 || oclr[c]) begin
                        md[d][c] = M_REC;
                        left[d][c] = RC;
                    end
                end else begin
                    if (left[d][c] == 1) md[d][c] = M_IDLE;
                    else left[d][c] = left[d][c] - 1;
                end
                if (cclr[c]) cnt[d][c] = inc ? 1 : 0;
                else if (inc && cnt[d][c] < cmax[d]) cnt[d][c] = cnt[d][c] + 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(int d, int m);
        logic [31:0] r = '0;
        for (int c = 0; c < 4; c++) r[c] = (md[d][c] == m);
        return r;
    endfunction

    function automatic logic [31:0] exp_cnt(int d);
        logic [31:0] r = '0;
        for (int c = 0; c < 4; c++) r = r | (32'(cnt[d][c]) << (c * cw[d]));
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_en",  32'(ifa.o_buffer_enable),     exp_vec(0, M_ACT));
        chk("a_ovf", 32'(ifa.o_overflow_detected), exp_vec(0, M_OVF));
        chk("a_rec", 32'(ifa.o_recovering),        exp_vec(0, M_REC));
        chk("a_any", 32'(ifa.o_overflow_any),      32'(|exp_vec(0, M_OVF)));
        chk("a_cnt", 32'(ifa.o_overflow_count),    exp_cnt(0));
        chk("b_en",  32'(ifb.o_buffer_enable),     exp_vec(1, M_ACT));
        chk("b_ovf", 32'(ifb.o_overflow_detected), exp_vec(1, M_OVF));
        chk("b_rec", 32'(ifb.o_recovering),        exp_vec(1, M_REC));
        chk("b_any", 32'(ifb.o_overflow_any),      32'(|exp_vec(1, M_OVF)));
        chk("b_cnt", 32'(ifb.o_overflow_count),    exp_cnt(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_en0(string nm);
        int n = 0;
        while (!ifa.o_buffer_enable[0] && n < 20) begin
            step();
            n++;
        end
        if (!ifa.o_buffer_enable[0]) begin
            errors++;
            $display("FAIL %s timeout act=0 exp=1", nm);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] ovf;
        logic [3:0] oclr;
        logic [3:0] cclr;
        logic [3:0] en;
        logic [3:0] ov;
        logic [3:0] rec;
        logic [1:0] c0;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
        tbl[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
        tbl[2]  = '{1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 2'd0};
        tbl[3]  = '{1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 2'd0};
        tbl[4]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 2'd0};
        tbl[5]  = '{1'b0, 4'h5, 4'h1, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0, 2'd1};
        tbl[6]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h1, 2'd1};
        tbl[7]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h1, 2'd1};
        tbl[8]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h1, 2'd1};
        tbl[9]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1};
        tbl[10] = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 2'd1};
        tbl[11] = '{1'b0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1};
        tbl[12] = '{1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 2'd1};

        for (int i = 0; i < 13; i++) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            ovf  = tbl[i].ovf;
            oclr = tbl[i].oclr;
            cclr = tbl[i].cclr;
            step();
            chk($sformatf("tbl%0d_en", i),  32'(ifa.o_buffer_enable),     32'(tbl[i].en));
            chk($sformatf("tbl%0d_ov", i),  32'(ifa.o_overflow_detected), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_rec", i), 32'(ifa.o_recovering),        32'(tbl[i].rec));
            chk($sformatf("tbl%0d_c0", i),  32'(ifa.o_overflow_count[1:0]), 32'(tbl[i].c0));
        end
        ovf = '0;

        // Saturation on channel 0 of the 2-bit counter instance.
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            wait_en0("sat_wait");
            ovf = 4'b0001;
            step();
            ovf = '0;
        end
        chk("sat_cnt", 32'(ifa.o_overflow_count[1:0]), 32'd3);
        wait_en0("clr_wait");
        ovf  = 4'b0001;
        cclr = 4'b0001;
        step();
        chk("clr_inc_cnt", 32'(ifa.o_overflow_count[1:0]), 32'd1);
        ovf = '0;
        step();
        chk("clr_only_cnt", 32'(ifa.o_overflow_count[1:0]), 32'd0);
        cclr = '0;

        // Sticky hold on channel 1 of the sticky instance.
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        req = 4'b0010;
        step();
        ovf = 4'b0010;
        step();
        ovf = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("sticky_hold%0d", k), 32'(ifb.o_overflow_detected[1]), 32'd1);
        end
        oclr = 4'b0010;
        step();
        oclr = '0;
        chk("sticky_rec", 32'(ifb.o_recovering[1]), 32'd1);
        chk("sticky_ovf_off", 32'(ifb.o_overflow_detected[1]), 32'd0);

        // Reset in the middle of RECOVER (ch1) and OVERFLOW (ch3).
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        req = 4'b1010;
        step();
        ovf = 4'b0010;
        step();
        ovf  = 4'b1000;
        oclr = 4'b0010;
        step();
        ovf  = '0;
        oclr = '0;
        chk("mid_a_rec1", 32'(ifa.o_recovering[1]), 32'd1);
        chk("mid_b_ovf3", 32'(ifb.o_overflow_detected[3]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_a_out", {ifa.o_buffer_enable, ifa.o_overflow_detected,
                          ifa.o_recovering, 20'd0}, 32'd0);
        chk("rst_a_cnt", 32'(ifa.o_overflow_count), 32'd0);
        chk("rst_b_out", {ifb.o_buffer_enable, ifb.o_overflow_detected,
                          ifb.o_recovering, 20'd0}, 32'd0);
        chk("rst_b_cnt", 32'(ifb.o_overflow_count), 32'd0);
        chk("rst_any", 32'({ifa.o_overflow_any, ifb.o_overflow_any}), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < 4; c++) begin
                req[c]  = ($urandom_range(0, 9) < 8);
                ovf[c]  = ($urandom_range(0, 9) < 2);
                oclr[c] = ($urandom_range(0, 19) < 3);
                cclr[c] = ($urandom_range(0, 19) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
